// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters for the Y86 pipeline.
// Decode is stalled while a source register has an outstanding write or while
// a destination counter has no room for the new pending write(s). Writeback
// releases entries, flush clears the board and err latches a release underflow.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [3:0]      issue_srcA,
    input  logic [3:0]      issue_srcB,
    input  logic [3:0]      issue_dstE,
    input  logic [3:0]      issue_dstM,
    output logic            issue_ready,
    input  logic            wbE_valid,
    input  logic [3:0]      wbE_reg,
    input  logic            wbM_valid,
    input  logic [3:0]      wbM_reg,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            drained,
    output logic            err
);

    localparam logic [3:0] NONREG = 4'hF;
    localparam int         MAXV   = (1 << CNT_W) - 1;
    localparam logic signed [CNT_W+1:0] ONE = 1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  uflow;
    logic             accept;
    logic signed [CNT_W+1:0] sum;

    // Clamp a signed net count at zero; the caller flags the underflow.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+1:0] v);
        if (v < 0) begin
            return '0;
        end
        return v[CNT_W-1:0];
    endfunction

    // Stall decision from registered counters and the current decode selections only.
    always_comb begin
        issue_ready = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if ((issue_srcA != NONREG) && (issue_srcA == 4'(r)) && (cnt[r] != '0)) begin
                issue_ready = 1'b0;
            end
            if ((issue_srcB != NONREG) && (issue_srcB == 4'(r)) && (cnt[r] != '0)) begin
                issue_ready = 1'b0;
            end
            if ((issue_dstE == 4'(r)) && (issue_dstM == 4'(r))) begin
                // Both ports target r: the instruction needs room for two pending writes.
                if (int'(cnt[r]) > MAXV - 2) begin
                    issue_ready = 1'b0;
                end
            end else if ((issue_dstE == 4'(r)) || (issue_dstM == 4'(r))) begin
                if (int'(cnt[r]) == MAXV) begin
                    issue_ready = 1'b0;
                end
            end
        end
    end

    assign accept = issue_valid & issue_ready;

    // Net per-register update: accepted increments minus writeback releases, clamped at zero.
    always_comb begin
        sum      = '0;
        busy_nxt = '0;
        uflow    = '0;
        for (int r = 0; r < NREG; r++) begin
            sum = $signed({2'b00, cnt[r]});
            if (accept && (issue_dstE == 4'(r))) begin
                sum = sum + ONE;
            end
            if (accept && (issue_dstM == 4'(r))) begin
                sum = sum + ONE;
            end
            if (wbE_valid && (wbE_reg == 4'(r))) begin
                sum = sum - ONE;
            end
            if (wbM_valid && (wbM_reg == 4'(r))) begin
                sum = sum - ONE;
            end
            uflow[r]    = (sum < 0);
            cnt_nxt[r]  = sat_cnt(sum);
            busy_nxt[r] = (cnt_nxt[r] != '0);
        end
    end

    // Counter state and registered status; rst beats flush, flush beats accept/release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy    <= '0;
            drained <= 1'b1;
            err     <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy    <= '0;
            drained <= 1'b1;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            busy    <= busy_nxt;
            drained <= ~|busy_nxt;
            if (|uflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table followed by randomized
// traffic checked against a counting model of the pending-write rules.
module tb_reg_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, wbE_valid, wbM_valid;
    logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM, wbE_reg, wbM_reg;
    logic        issue_ready, drained, err;
    logic [14:0] busy;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .NREG(15)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
        .issue_dstE(issue_dstE), .issue_dstM(issue_dstM), .issue_ready(issue_ready),
        .wbE_valid(wbE_valid), .wbE_reg(wbE_reg), .wbM_valid(wbM_valid), .wbM_reg(wbM_reg),
        .flush(flush), .busy(busy), .drained(drained), .err(err)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [3:0]  sa, sb, de, dm;
        logic        wev;
        logic [3:0]  wer;
        logic        wmv;
        logic [3:0]  wmr;
        logic        e_ready;
        logic [14:0] e_busy;
        logic        e_drained, e_err;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    logic        s_ready, s_drained, s_err;
    logic [14:0] s_busy;
    vec_t        vt [30];
    int          mc [15];
    bit          merr;

    function automatic vec_t mk(input logic r, f, iv, input logic [3:0] sa, sb, de, dm,
                                input logic wev, input logic [3:0] wer,
                                input logic wmv, input logic [3:0] wmr,
                                input logic er, input logic [14:0] eb, input logic ed, ee);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.sa = sa; v.sb = sb; v.de = de; v.dm = dm;
        v.wev = wev; v.wer = wer; v.wmv = wmv; v.wmr = wmr;
        v.e_ready = er; v.e_busy = eb; v.e_drained = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Drive one cycle: ready sampled mid-cycle, registered outputs just after the edge.
    task automatic run_cycle(input vec_t v);
        rst = v.rst; flush = v.flush; issue_valid = v.iv;
        issue_srcA = v.sa; issue_srcB = v.sb; issue_dstE = v.de; issue_dstM = v.dm;
        wbE_valid = v.wev; wbE_reg = v.wer; wbM_valid = v.wmv; wbM_reg = v.wmr;
        @(negedge clk);
        s_ready = issue_ready;
        @(posedge clk);
        #1;
        s_busy = busy; s_drained = drained; s_err = err;
    endtask

    function automatic bit model_ready(input vec_t v);
        bit ok = 1'b1;
        if (v.sa != 4'hF && mc[v.sa] != 0) ok = 1'b0;
        if (v.sb != 4'hF && mc[v.sb] != 0) ok = 1'b0;
        if (v.de != 4'hF && v.de == v.dm) begin
            if (mc[v.de] + 2 > MAXC) ok = 1'b0;
        end else begin
            if (v.de != 4'hF && mc[v.de] + 1 > MAXC) ok = 1'b0;
            if (v.dm != 4'hF && mc[v.dm] + 1 > MAXC) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_step(input vec_t v, input bit rdy);
        int d [15];
        int n;
        for (int r = 0; r < 15; r++) d[r] = 0;
        if (v.rst) begin
            for (int r = 0; r < 15; r++) mc[r] = 0;
            merr = 1'b0;
        end else if (v.flush) begin
            for (int r = 0; r < 15; r++) mc[r] = 0;
        end else begin
            if (v.iv && rdy) begin
                if (v.de != 4'hF) d[v.de] += 1;
                if (v.dm != 4'hF) d[v.dm] += 1;
            end
            if (v.wev && v.wer != 4'hF) d[v.wer] -= 1;
            if (v.wmv && v.wmr != 4'hF) d[v.wmr] -= 1;
            for (int r = 0; r < 15; r++) begin
                n = mc[r] + d[r];
                if (n < 0) begin
                    n = 0;
                    merr = 1'b1;
                end
                mc[r] = n;
            end
        end
    endtask

    function automatic logic [3:0] rcode();
        if ($urandom_range(0, 3) == 0) return 4'hF;
        return 4'($urandom_range(0, 14));
    endfunction

    initial begin
        vec_t        v;
        bit          er;
        logic [14:0] eb;
        logic        F1;
        F1 = 1'b0;
        //         rst flush iv  srcA   srcB   dstE   dstM   wbE       wbM       ready busy      drn err
        vt[0]  = mk(0, 0, 0, 4'h3, 4'h4, 4'h3, 4'h3, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[1]  = mk(0, 0, 1, 4'hF, 4'hF, 4'h3, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0008, 0, 0);
        vt[2]  = mk(0, 0, 1, 4'h3, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 15'h0008, 0, 0);
        vt[3]  = mk(0, 0, 1, 4'h3, 4'hF, 4'hF, 4'hF, 1, 4'h3, 0, 4'hF, 0, 15'h0000, 1, 0);
        vt[4]  = mk(0, 0, 1, 4'h3, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[5]  = mk(0, 0, 1, 4'h4, 4'h4, 4'h4, 4'h4, 0, 4'hF, 0, 4'hF, 1, 15'h0010, 0, 0);
        vt[6]  = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h4, 0, 4'hF, 1, 15'h0010, 0, 0);
        vt[7]  = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 1, 4'h4, 1, 15'h0000, 1, 0);
        vt[8]  = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0004, 0, 0);
        vt[9]  = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0004, 0, 0);
        vt[10] = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0004, 0, 0);
        vt[11] = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 0, 15'h0004, 0, 0);
        vt[12] = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 1, 4'h2, 0, 4'hF, 0, 15'h0004, 0, 0);
        vt[13] = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0004, 0, 0);
        vt[14] = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h2, 1, 4'h2, 1, 15'h0004, 0, 0);
        vt[15] = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h2, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[16] = mk(0, 0, 1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0020, 0, 0);
        vt[17] = mk(0, 0, 1, 4'hF, 4'hF, 4'h5, 4'hF, 1, 4'h5, 0, 4'hF, 1, 15'h0020, 0, 0);
        vt[18] = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h5, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[19] = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 1, 4'h7, 1, 15'h0000, 1, 1);
        vt[20] = mk(0, 1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 1);
        vt[21] = mk(1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[22] = mk(0, 0, 1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0002, 0, 0);
        vt[23] = mk(0, 0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0006, 0, 0);
        vt[24] = mk(0, 0, 1, 4'hF, 4'hF, 4'h4, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0016, 0, 0);
        vt[25] = mk(0, 1, 1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[26] = mk(0, 0, 1, 4'h6, 4'h1, 4'h6, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0040, 0, 0);
        vt[27] = mk(1, 1, 1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);
        vt[28] = mk(0, 0, 1, 4'hF, 4'hF, 4'h8, 4'hF, 1, 4'h9, 0, 4'hF, 1, 15'h0100, 0, 1);
        vt[29] = mk(1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0000, 1, 0);

        // Initial reset, two cycles.
        v = mk(1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 1, 15'h0, 1, 0);
        run_cycle(v);
        run_cycle(v);
        check("reset_busy", 32'(s_busy), 32'h0);
        check("reset_drained", 32'(s_drained), 32'h1);
        check("reset_err", 32'(s_err), 32'h0);

        for (int i = 0; i < 30; i++) begin
            run_cycle(vt[i]);
            check($sformatf("v%0d_ready", i), 32'(s_ready), 32'(vt[i].e_ready));
            check($sformatf("v%0d_busy", i), 32'(s_busy), 32'(vt[i].e_busy));
            check($sformatf("v%0d_drained", i), 32'(s_drained), 32'(vt[i].e_drained));
            check($sformatf("v%0d_err", i), 32'(s_err), 32'(vt[i].e_err));
        end

        // Randomized traffic against the counting model; board is clean after vt[29].
        for (int r = 0; r < 15; r++) mc[r] = 0;
        merr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            v = mk(($urandom_range(0, 63) == 0) ? 1'b1 : F1,
                   ($urandom_range(0, 31) == 0) ? 1'b1 : F1,
                   1'($urandom_range(0, 1)), rcode(), rcode(), rcode(), rcode(),
                   ($urandom_range(0, 2) == 0) ? 1'b1 : F1, rcode(),
                   ($urandom_range(0, 3) == 0) ? 1'b1 : F1, rcode(),
                   1'b0, 15'h0, 1'b0, 1'b0);
            er = model_ready(v);
            run_cycle(v);
            model_step(v, er);
            eb = '0;
            for (int r = 0; r < 15; r++) eb[r] = (mc[r] != 0);
            check($sformatf("rnd%0d_ready", i), 32'(s_ready), 32'(er));
            check($sformatf("rnd%0d_busy", i), 32'(s_busy), 32'(eb));
            check($sformatf("rnd%0d_drained", i), 32'(s_drained), 32'(eb == 15'h0));
            check($sformatf("rnd%0d_err", i), 32'(s_err), 32'(merr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file hazard scoreboard for the Y86 pipeline. It sits beside the register file between decode and writeback and tracks outstanding writes per architectural register. It takes the srcA/srcB/dstE/dstM selections from the decode-stage selectors and stalls issue while any source register has a pending write. Writeback releases entries, and a flush clears the board.

## Interface

Parameters:
- `CNT_W`, default 2: width of each per-register pending-write counter; maximum count is 2^CNT_W-1.
- `NREG`, default 15: number of tracked registers, codes 0..14. Code 4'hF (`NonReg_`) means "no register".

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `issue_valid` input 1: decode presents an instruction this cycle.
- `issue_srcA` input 4: source A register code, F = none.
- `issue_srcB` input 4: source B register code, F = none.
- `issue_dstE` input 4: E-port destination code, F = none.
- `issue_dstM` input 4: M-port destination code, F = none.
- `issue_ready` output 1: instruction may issue this cycle.
- `wbE_valid` input 1: writeback E port writes `wbE_reg` this cycle.
- `wbE_reg` input 4: E-port writeback register.
- `wbM_valid` input 1: writeback M port writes `wbM_reg` this cycle.
- `wbM_reg` input 4: M-port writeback register.
- `flush` input 1: clear all pending entries (pipeline squashed/drained).
- `busy` output NREG: bit r = 1 when counter r is non-zero (registered).
- `drained` output 1: all counters are zero (registered).
- `err` output 1: sticky error, underflow on release.

## Operation

- State: NREG counters `cnt[r]` of CNT_W bits, plus the `err` flip-flop.
- Code F on any src/dst/wb input is ignored.
- `issue_ready` is combinational from registered state and current issue inputs only. It is 0 when any of the following holds:
  - srcA ≠ F and cnt[srcA] ≠ 0.
  - srcB ≠ F and cnt[srcB] ≠ 0.
  - The dst increment would exceed the maximum: dstE = dstM ≠ F and cnt > max-2; or, for a single dst d ≠ F, cnt[d] = max.
- `issue_ready` does not depend on `issue_valid`. There is no same-cycle bypass of writeback releases into `issue_ready`.
- Accept: `issue_valid & issue_ready` at the edge.
  - cnt[dstE] += 1 if dstE ≠ F; cnt[dstM] += 1 if dstM ≠ F.
  - dstE = dstM (e.g. popq %rsp) adds 2.
- Release: `wbE_valid` with wbE_reg ≠ F gives −1 on that register; likewise for the M port. Both ports on the same register give −2.
- Net update per register = increments − decrements, applied in one edge. Simultaneous accept and release on the same register nets out; for example, +1 and −1 leave the count unchanged.
- Underflow: if a release would take a counter below 0:
  - The counter saturates at 0.
  - `err` is set and holds until `rst`.
  - Other registers update normally.
- `flush` takes priority over accepts and releases on that edge: all counters go to 0. `err` is unaffected by `flush`.
- `busy` and `drained` are registered outputs. They reflect the counters after the edge.

## Timing

- Reset values: all cnt = 0, `busy` = 0, `drained` = 1, `err` = 0. After reset, `issue_ready` = 1 for any inputs.
- `rst` asserted mid-operation overrides `flush`, accepts and releases on that edge.
- Issue-to-busy latency: 1 cycle. An accept at edge N shows `busy` set after edge N.
- RAW stall release: writeback at edge N clears the counter after edge N. A dependent instruction sees `issue_ready` = 1 in cycle N+1, so its earliest accept is edge N+1.
- `flush` at edge N: `issue_ready` depends only on current inputs from cycle N+1; `drained` = 1 after edge N.
- Counter at max with a same-cycle release on that register: `issue_ready` still 0 (conservative, registered state only).

## Test plan

- Reset, then issue irmovq: dstE = 3, others F, valid → accepted; busy[3] = 1, drained = 0 next cycle. Next issue with srcA = 3 → issue_ready = 0. Pulse wbE_valid with reg 3 → issue_ready = 1 the following cycle; busy = 0, drained = 1.
- popq %rsp: srcA = 4, srcB = 4, dstE = 4, dstM = 4, cnt[4] = 0 → accepted, cnt[4] = 2. wbE(4) one cycle → busy[4] still 1. wbM(4) next cycle → busy[4] = 0.
- Three back-to-back accepts with dstE = 2 (CNT_W = 2) → cnt[2] = 3. Fourth with dstE = 2 → issue_ready = 0. Same cycle as a fourth attempt, wbE(2) plus accept → blocked. Next cycle the fourth is accepted, cnt stays 3.
- Same-edge accept (dstE = 5) and wbE(5) with cnt[5] = 1 → cnt[5] remains 1, busy[5] = 1, err = 0.
- wbM(7) with cnt[7] = 0 → err = 1, cnt[7] = 0. Then flush → err stays 1. Then rst → err = 0.
- Pending writes on regs 1, 2, 4 plus same-edge accept (dstE = 6) and flush → all busy = 0, drained = 1, cnt[6] = 0.
